// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the on-chip RAM arbiter.
package onchip_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 13;
    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned MEM_BE_W   = 2;
    localparam int unsigned MEM_DEPTH  = 8192;

    typedef enum logic {CLEAR, ARB} arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_cmd_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// 2-way round-robin grant; the pointer names the requester that wins the next contention.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_o  = req_i;
        prio_d = prio_q;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester sequencer for the single-port on-chip RAM with an optional zero-fill sweep after reset.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned BE_W           = MEM_BE_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_write,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic [BE_W-1:0]   rq0_be,
    output logic              rs0_valid,
    output logic [DATA_W-1:0] rs0_data,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_write,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    input  logic [BE_W-1:0]   rq1_be,
    output logic              rs1_valid,
    output logic [DATA_W-1:0] rs1_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy_clear
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_id_q, rd_id_d;
    logic              rs0_valid_q, rs1_valid_q;
    logic [DATA_W-1:0] rs0_data_q, rs1_data_q;
    logic [1:0]        req, gnt;
    mem_cmd_t          cmd0, cmd1, cmd;

    // Requests are masked during reset so nothing is accepted or issued in a reset cycle.
    assign req = (state_q == ARB && !reset) ? {rq1_valid, rq0_valid} : 2'b00;

    rr_arbiter2 u_rr (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req),
        .gnt_o   (gnt)
    );

    assign cmd0 = '{write: rq0_write, addr: rq0_addr, wdata: rq0_wdata, be: rq0_be};
    assign cmd1 = '{write: rq1_write, addr: rq1_addr, wdata: rq1_wdata, be: rq1_be};
    assign cmd  = gnt[1] ? cmd1 : cmd0;

    assign rq0_ready  = gnt[0];
    assign rq1_ready  = gnt[1];
    assign mem_clken  = 1'b1;
    assign busy_clear = (state_q == CLEAR);
    assign rs0_valid  = rs0_valid_q;
    assign rs1_valid  = rs1_valid_q;
    assign rs0_data   = rs0_data_q;
    assign rs1_data   = rs1_data_q;

    always_comb begin
        state_d        = state_q;
        clr_d          = clr_q;
        rd_pend_d      = 1'b0;
        rd_id_d        = rd_id_q;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '1;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = clr_q;
                clr_d          = clr_q + 1'b1;
                if (&clr_q) begin
                    state_d = ARB;
                end
            end else if (|gnt) begin
                mem_chipselect = 1'b1;
                mem_write      = cmd.write;
                mem_address    = cmd.addr;
                mem_writedata  = cmd.wdata;
                mem_byteenable = cmd.write ? cmd.be : '1;
                rd_pend_d      = !cmd.write;
                rd_id_d        = gnt[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : ARB;
            clr_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= 1'b0;
            rs0_valid_q <= 1'b0;
            rs1_valid_q <= 1'b0;
            rs0_data_q  <= '0;
            rs1_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            // RAM output is valid the cycle after issue; capture it into the response register.
            rs0_valid_q <= rd_pend_q && !rd_id_q;
            rs1_valid_q <= rd_pend_q && rd_id_q;
            if (rd_pend_q && !rd_id_q) begin
                rs0_data_q <= mem_readdata;
            end
            if (rd_pend_q && rd_id_q) begin
                rs1_data_q <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: dut A sweeps on reset, dut B starts directly in arbitration.
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic        rst_a, rst_b;
    logic        a_rq0_valid, a_rq0_ready, a_rq0_write, a_rs0_valid;
    logic [12:0] a_rq0_addr;
    logic [15:0] a_rq0_wdata, a_rs0_data;
    logic [1:0]  a_rq0_be;
    logic        a_rq1_valid, a_rq1_ready, a_rq1_write, a_rs1_valid;
    logic [12:0] a_rq1_addr;
    logic [15:0] a_rq1_wdata, a_rs1_data;
    logic [1:0]  a_rq1_be;
    logic [12:0] a_addr;
    logic [1:0]  a_be;
    logic        a_cs, a_we, a_clken, a_busy;
    logic [15:0] a_wd, a_rd;

    logic        b_rq0_valid, b_rq0_ready, b_rq0_write, b_rs0_valid;
    logic [12:0] b_rq0_addr;
    logic [15:0] b_rq0_wdata, b_rs0_data;
    logic [1:0]  b_rq0_be;
    logic        b_rq1_valid, b_rq1_ready, b_rq1_write, b_rs1_valid;
    logic [12:0] b_rq1_addr;
    logic [15:0] b_rq1_wdata, b_rs1_data;
    logic [1:0]  b_rq1_be;
    logic [12:0] b_addr;
    logic [1:0]  b_be;
    logic        b_cs, b_we, b_clken, b_busy;
    logic [15:0] b_wd, b_rd;

    onchip_mem_arbiter #(.CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset(rst_a),
        .rq0_valid(a_rq0_valid), .rq0_ready(a_rq0_ready), .rq0_write(a_rq0_write),
        .rq0_addr(a_rq0_addr), .rq0_wdata(a_rq0_wdata), .rq0_be(a_rq0_be),
        .rs0_valid(a_rs0_valid), .rs0_data(a_rs0_data),
        .rq1_valid(a_rq1_valid), .rq1_ready(a_rq1_ready), .rq1_write(a_rq1_write),
        .rq1_addr(a_rq1_addr), .rq1_wdata(a_rq1_wdata), .rq1_be(a_rq1_be),
        .rs1_valid(a_rs1_valid), .rs1_data(a_rs1_data),
        .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs),
        .mem_write(a_we), .mem_writedata(a_wd), .mem_clken(a_clken),
        .mem_readdata(a_rd), .busy_clear(a_busy)
    );

    onchip_mem_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .reset(rst_b),
        .rq0_valid(b_rq0_valid), .rq0_ready(b_rq0_ready), .rq0_write(b_rq0_write),
        .rq0_addr(b_rq0_addr), .rq0_wdata(b_rq0_wdata), .rq0_be(b_rq0_be),
        .rs0_valid(b_rs0_valid), .rs0_data(b_rs0_data),
        .rq1_valid(b_rq1_valid), .rq1_ready(b_rq1_ready), .rq1_write(b_rq1_write),
        .rq1_addr(b_rq1_addr), .rq1_wdata(b_rq1_wdata), .rq1_be(b_rq1_be),
        .rs1_valid(b_rs1_valid), .rs1_data(b_rs1_data),
        .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs),
        .mem_write(b_we), .mem_writedata(b_wd), .mem_clken(b_clken),
        .mem_readdata(b_rd), .busy_clear(b_busy)
    );

    // RAM models: registered address, unregistered output, byte-enabled writes.
    logic [15:0] mem_a [0:8191];
    logic [15:0] mem_b [0:8191];
    logic [12:0] raddr_a = '0;
    logic [12:0] raddr_b = '0;

    always @(posedge clk) begin
        if (a_cs && a_clken) begin
            if (a_we && a_be[0]) mem_a[a_addr][7:0]  <= a_wd[7:0];
            if (a_we && a_be[1]) mem_a[a_addr][15:8] <= a_wd[15:8];
            raddr_a <= a_addr;
        end
        if (b_cs && b_clken) begin
            if (b_we && b_be[0]) mem_b[b_addr][7:0]  <= b_wd[7:0];
            if (b_we && b_be[1]) mem_b[b_addr][15:8] <= b_wd[15:8];
            raddr_b <= b_addr;
        end
    end
    assign a_rd = mem_a[raddr_a];
    assign b_rd = mem_b[raddr_b];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic req, input logic [12:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
        if (!req) begin
            a_rq0_valid = 1'b1; a_rq0_write = 1'b1; a_rq0_addr = addr;
            a_rq0_wdata = data; a_rq0_be = be;
        end else begin
            a_rq1_valid = 1'b1; a_rq1_write = 1'b1; a_rq1_addr = addr;
            a_rq1_wdata = data; a_rq1_be = be;
        end
        tick();
        a_rq0_valid = 1'b0;
        a_rq1_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (a_rq0_ready !== 1'b0 || a_rq1_ready !== 1'b0 || a_cs !== 1'b0 || a_we !== 1'b0 ||
            a_addr !== 13'd0 || a_rs0_valid !== 1'b0 || a_rs1_valid !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL reset_state: rdy=%b%b cs=%b we=%b addr=%h rsv=%b%b busy=%b required 00 0 0 0000 00 1",
                     a_rq1_ready, a_rq0_ready, a_cs, a_we, a_addr, a_rs1_valid, a_rs0_valid, a_busy);
        end else passed++;
        checks++;
        if (a_rs0_data !== 16'h0 || a_rs1_data !== 16'h0 || a_clken !== 1'b1) begin
            $display("FAIL reset_data: rs0=%h rs1=%h clken=%b required 0000 0000 1",
                     a_rs0_data, a_rs1_data, a_clken);
        end else passed++;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_sweep();
        int unsigned errs = 0;
        int unsigned first_bad = 0;
        for (int unsigned i = 0; i < 8192; i++) begin
            #1;
            if (a_cs !== 1'b1 || a_we !== 1'b1 || a_addr !== 13'(i) || a_wd !== 16'h0 ||
                a_be !== 2'b11 || a_rq0_ready !== 1'b0 || a_rq1_ready !== 1'b0 || a_busy !== 1'b1) begin
                if (errs == 0) first_bad = i;
                errs++;
            end
            tick();
        end
        checks++;
        if (errs !== 0) $display("FAIL sweep: %0d bad cycles (first %0d) required 0", errs, first_bad);
        else passed++;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_rq0_ready !== 1'b1 || a_rq1_ready !== 1'b0) begin
            $display("FAIL first_grant: busy=%b rdy0=%b rdy1=%b required 0 1 0", a_busy, a_rq0_ready, a_rq1_ready);
        end else passed++;
        checks++;
        if (a_cs !== 1'b1 || a_we !== 1'b1 || a_addr !== 13'h0010 || a_wd !== 16'hBEEF || a_be !== 2'b11) begin
            $display("FAIL first_cmd: cs=%b we=%b addr=%h wd=%h be=%b required 1 1 0010 beef 11",
                     a_cs, a_we, a_addr, a_wd, a_be);
        end else passed++;
    endtask

    task automatic test_write_read();
        int unsigned bad_rs0 = 0;
        tick();
        a_rq0_valid = 1'b0;
        #1;
        checks++;
        if (a_rq1_ready !== 1'b1 || a_we !== 1'b0 || a_addr !== 13'h0010 || a_be !== 2'b11) begin
            $display("FAIL read_cmd: rdy1=%b we=%b addr=%h be=%b required 1 0 0010 11",
                     a_rq1_ready, a_we, a_addr, a_be);
        end else passed++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            a_rq1_valid = 1'b0;
            #1;
            if (a_rs0_valid !== 1'b0) bad_rs0++;
            if (c == 1) begin
                checks++;
                if (a_rs1_valid !== 1'b0) $display("FAIL rd_latency_early: rs1_valid=%b required 0", a_rs1_valid);
                else passed++;
            end else if (c == 2) begin
                checks++;
                if (a_rs1_valid !== 1'b1 || a_rs1_data !== 16'hBEEF)
                    $display("FAIL rd_beef: valid=%b data=%h required 1 beef", a_rs1_valid, a_rs1_data);
                else passed++;
            end else begin
                checks++;
                if (a_rs1_valid !== 1'b0) $display("FAIL rd_pulse_width: rs1_valid=%b required 0", a_rs1_valid);
                else passed++;
            end
        end
        checks++;
        if (bad_rs0 !== 0) $display("FAIL rs0_idle: %0d cycles with rs0_valid required 0", bad_rs0);
        else passed++;
    endtask

    task automatic test_byte_enable();
        a_write(1'b0, 13'd5, 16'h1234, 2'b11);
        a_write(1'b0, 13'd5, 16'hAB00, 2'b10);
        a_rq1_valid = 1'b1; a_rq1_write = 1'b0; a_rq1_addr = 13'd5;
        tick();
        a_rq1_valid = 1'b0;
        tick();
        checks++;
        if (a_rs1_valid !== 1'b1 || a_rs1_data !== 16'hAB34)
            $display("FAIL byte_enable: valid=%b data=%h required 1 ab34", a_rs1_valid, a_rs1_data);
        else passed++;
    endtask

    task automatic test_contention();
        int i0 = 0;
        int i1 = 0;
        for (int k = 0; k < 3; k++) a_write(1'b0, 13'h100 + 13'(k), 16'h1000 + 16'(k), 2'b11);
        for (int k = 0; k < 3; k++) a_write(1'b1, 13'h200 + 13'(k), 16'h2000 + 16'(k), 2'b11);
        tick();
        for (int c = 0; c < 9; c++) begin
            a_rq0_valid = (i0 < 3); a_rq0_write = 1'b0; a_rq0_addr = 13'h100 + 13'(i0);
            a_rq1_valid = (i1 < 3); a_rq1_write = 1'b0; a_rq1_addr = 13'h200 + 13'(i1);
            #1;
            if (c < 6) begin
                checks++;
                if (a_rq0_ready !== (c % 2 == 0) || a_rq1_ready !== (c % 2 == 1))
                    $display("FAIL rr_grant c%0d: rdy0=%b rdy1=%b required %0d %0d",
                             c, a_rq0_ready, a_rq1_ready, c % 2 == 0, c % 2 == 1);
                else passed++;
            end
            checks++;
            if (c >= 2 && c <= 6 && c % 2 == 0) begin
                if (a_rs0_valid !== 1'b1 || a_rs0_data !== 16'h1000 + 16'((c - 2) / 2))
                    $display("FAIL rr_rs0 c%0d: valid=%b data=%h required 1 %h",
                             c, a_rs0_valid, a_rs0_data, 16'h1000 + 16'((c - 2) / 2));
                else passed++;
            end else if (a_rs0_valid !== 1'b0) begin
                $display("FAIL rr_rs0 c%0d: valid=%b required 0", c, a_rs0_valid);
            end else passed++;
            checks++;
            if (c >= 3 && c <= 7 && c % 2 == 1) begin
                if (a_rs1_valid !== 1'b1 || a_rs1_data !== 16'h2000 + 16'((c - 3) / 2))
                    $display("FAIL rr_rs1 c%0d: valid=%b data=%h required 1 %h",
                             c, a_rs1_valid, a_rs1_data, 16'h2000 + 16'((c - 3) / 2));
                else passed++;
            end else if (a_rs1_valid !== 1'b0) begin
                $display("FAIL rr_rs1 c%0d: valid=%b required 0", c, a_rs1_valid);
            end else passed++;
            if (a_rq0_valid && a_rq0_ready) i0++;
            if (a_rq1_valid && a_rq1_ready) i1++;
            tick();
        end
        a_rq0_valid = 1'b0;
        a_rq1_valid = 1'b0;
    endtask

    task automatic test_boundary();
        logic [12:0] addrs [3];
        logic [15:0] exp [3];
        addrs[0] = 13'h1FFF; addrs[1] = 13'h0000; addrs[2] = 13'h0ABC;
        exp[0] = 16'h5A5A; exp[1] = 16'hA5A5; exp[2] = 16'h0000;
        a_write(1'b0, 13'h1FFF, 16'h5A5A, 2'b11);
        a_write(1'b0, 13'h0000, 16'hA5A5, 2'b11);
        tick();
        for (int c = 0; c < 5; c++) begin
            a_rq1_valid = (c < 3); a_rq1_write = 1'b0;
            if (c < 3) a_rq1_addr = addrs[c];
            #1;
            if (c < 3) begin
                checks++;
                if (a_rq1_ready !== 1'b1 || a_addr !== addrs[c])
                    $display("FAIL bnd_issue c%0d: rdy1=%b addr=%h required 1 %h", c, a_rq1_ready, a_addr, addrs[c]);
                else passed++;
            end
            if (c >= 2) begin
                checks++;
                if (a_rs1_valid !== 1'b1 || a_rs1_data !== exp[c - 2] || a_rs0_valid !== 1'b0)
                    $display("FAIL bnd_resp c%0d: valid=%b data=%h rs0v=%b required 1 %h 0",
                             c, a_rs1_valid, a_rs1_data, a_rs0_valid, exp[c - 2]);
                else passed++;
            end
            tick();
        end
        a_rq1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        tick();
        checks++;
        if (b_busy !== 1'b0 || b_rq0_ready !== 1'b0 || b_rs0_data !== 16'h0)
            $display("FAIL b_reset_state: busy=%b rdy0=%b rs0=%h required 0 0 0000", b_busy, b_rq0_ready, b_rs0_data);
        else passed++;
        rst_b = 1'b0;
        b_rq0_valid = 1'b1; b_rq0_write = 1'b0; b_rq0_addr = 13'd3;
        #1;
        checks++;
        if (b_rq0_ready !== 1'b1 || b_cs !== 1'b1)
            $display("FAIL b_no_sweep: rdy0=%b cs=%b required 1 1", b_rq0_ready, b_cs);
        else passed++;
        tick();
        rst_b = 1'b1;
        b_rq1_valid = 1'b1; b_rq1_write = 1'b0; b_rq1_addr = 13'd4;
        #1;
        checks++;
        if (b_rq0_ready !== 1'b0 || b_rq1_ready !== 1'b0 || b_cs !== 1'b0 || b_addr !== 13'd0)
            $display("FAIL b_reset_cycle: rdy=%b%b cs=%b addr=%h required 00 0 0000",
                     b_rq1_ready, b_rq0_ready, b_cs, b_addr);
        else passed++;
        tick();
        rst_b = 1'b0;
        b_rq0_valid = 1'b0;
        b_rq1_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (b_rs0_valid !== 1'b0 || b_rs1_valid !== 1'b0)
                $display("FAIL b_no_resp c%0d: rs0v=%b rs1v=%b required 0 0", c, b_rs0_valid, b_rs1_valid);
            else passed++;
            tick();
        end
        b_rq0_valid = 1'b1;
        b_rq1_valid = 1'b1;
        #1;
        checks++;
        if (b_rq0_ready !== 1'b1 || b_rq1_ready !== 1'b0)
            $display("FAIL b_prio_after_reset: rdy0=%b rdy1=%b required 1 0", b_rq0_ready, b_rq1_ready);
        else passed++;
        tick();
        b_rq0_valid = 1'b0;
        b_rq1_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem_a[i] = 16'hDEAD;
        rst_a = 1'b1; rst_b = 1'b1;
        a_rq0_valid = 1'b1; a_rq0_write = 1'b1; a_rq0_addr = 13'h0010;
        a_rq0_wdata = 16'hBEEF; a_rq0_be = 2'b11;
        a_rq1_valid = 1'b1; a_rq1_write = 1'b0; a_rq1_addr = 13'h0010;
        a_rq1_wdata = 16'h0; a_rq1_be = 2'b00;
        b_rq0_valid = 1'b0; b_rq0_write = 1'b0; b_rq0_addr = '0; b_rq0_wdata = '0; b_rq0_be = '0;
        b_rq1_valid = 1'b0; b_rq1_write = 1'b0; b_rq1_addr = '0; b_rq1_wdata = '0; b_rq1_be = '0;
        test_reset();
        test_sweep();
        test_write_read();
        test_byte_enable();
        test_contention();
        test_boundary();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
